ps2_kbd_tx: RTL and testbench

- Device-side PS/2 keyboard transmitter. Converts key press/release events into scancode byte sequences: make = code; break = F0, code.
- Serialises each byte as a PS/2 device-to-host frame and generates ps2_clk itself.
- Acts as the keyboard model and stimulus source feeding the PS/2 receiver and keyboard display path on the NPC board top.
- Host-to-device traffic and host clock inhibit are out of scope.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_kbd_tx_if.sv | 16 +
 rtl/ps2_frame_ser.sv | 119 +++++++++++
 rtl/ps2_kbd_tx.sv | 107 ++++++++++
 tb/tb_ps2_kbd_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encodings and the odd-parity helper for the PS/2 keyboard transmitter.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_PFX  = 8'hF0;
  localparam logic [7:0] PS2_EXT_PFX    = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    SEND_EXT,
    SEND_PFX,
    SEND_CODE,
    DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_HIGH,
    F_LOW,
    F_GAP
  } frm_state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Key-event handshake between a key source and ps2_kbd_tx; key_ext exists only with PS2_EXT_KEY_EN.
interface ps2_kbd_tx_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
`ifdef PS2_EXT_KEY_EN
  logic       key_ext;

  modport master (output key_valid, output key_code, output key_break, output key_ext, input key_ready);
  modport slave  (input key_valid, input key_code, input key_break, input key_ext, output key_ready);
`else
  modport master (output key_valid, output key_code, output key_break, input key_ready);
  modport slave  (input key_valid, input key_code, input key_break, output key_ready);
`endif
endinterface

// File: rtl/ps2_frame_ser.sv
// Serialises one byte as an 11-bit PS/2 device-to-host frame plus idle gap; first high phase starts the cycle after start.
// No backpressure: start is only honoured when idle or on the last gap cycle, giving gapless chained frames.
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 2500,
  parameter int GAP_HALVES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       frame_done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  frm_state_t       state, state_n;
  logic [HW-1:0]    hcnt, hcnt_n;
  logic [3:0]       bcnt, bcnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [10:0]      sh, sh_n;
  logic             clk_n, dat_n;
  logic             half_end;

  assign half_end = (hcnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= F_IDLE;
      hcnt     <= HALF_LAST;
      bcnt     <= '0;
      gcnt     <= '0;
      sh       <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      bcnt     <= bcnt_n;
      gcnt     <= gcnt_n;
      sh       <= sh_n;
      ps2_clk  <= clk_n;
      ps2_data <= dat_n;
    end
  end

  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    bcnt_n     = bcnt;
    gcnt_n     = gcnt;
    sh_n       = sh;
    clk_n      = ps2_clk;
    dat_n      = ps2_data;
    frame_done = 1'b0;
    case (state)
      F_IDLE: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
      end
      F_HIGH: begin
        hcnt_n = hcnt - 1'b1;
        if (half_end) begin
          state_n = F_LOW;
          hcnt_n  = HALF_LAST;
          clk_n   = 1'b0;
        end
      end
      F_LOW: begin
        hcnt_n = hcnt - 1'b1;
        if (half_end) begin
          hcnt_n = HALF_LAST;
          clk_n  = 1'b1;
          if (bcnt == LAST_BIT) begin
            state_n = F_GAP;
            gcnt_n  = '0;
            dat_n   = 1'b1;
          end else begin
            // Data only moves as the clock goes high, so it is stable at the host's falling-edge sample.
            state_n = F_HIGH;
            bcnt_n  = bcnt + 4'd1;
            dat_n   = sh[1];
            sh_n    = {1'b1, sh[10:1]};
          end
        end
      end
      F_GAP: begin
        hcnt_n = hcnt - 1'b1;
        if (half_end) begin
          hcnt_n = HALF_LAST;
          if (gcnt == GAP_LAST) begin
            frame_done = 1'b1;
            state_n    = F_IDLE;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
      end
      default: state_n = F_IDLE;
    endcase

    if (start && (state == F_IDLE || frame_done)) begin
      state_n = F_HIGH;
      hcnt_n  = HALF_LAST;
      bcnt_n  = '0;
      sh_n    = {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
      clk_n   = 1'b1;
      dat_n   = 1'b0;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard event sequencer: make -> code, break -> F0 code (E0 prefix with PS2_EXT_KEY_EN); tx_done on last gap cycle.
// Handshake key_ready = ~busy; one event in flight, next accept possible the edge after busy drops.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 2500,
  parameter int GAP_HALVES = 2
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  key,
  output logic         ps2_clk,
  output logic         ps2_data,
  output logic         busy,
  output logic         tx_done
);

  seq_state_t state, state_n, ser_sel, first_state;
  logic [7:0] code_q;
  logic       brk_q;
  logic       kick;
  logic       accept;
  logic       ser_start;
  logic       frame_done;
  logic [7:0] ser_byte;

  assign key.key_ready = ~busy;
  assign accept        = key.key_valid & ~busy;

`ifdef PS2_EXT_KEY_EN
  logic ext_q;

  assign first_state = key.key_ext ? SEND_EXT : (key.key_break ? SEND_PFX : SEND_CODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ext_q <= 1'b0;
    else if (accept) ext_q <= key.key_ext;
  end
`else
  assign first_state = key.key_break ? SEND_PFX : SEND_CODE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      kick   <= 1'b0;
      code_q <= '0;
      brk_q  <= 1'b0;
    end else begin
      state <= state_n;
      kick  <= accept;
      if (accept) begin
        busy   <= 1'b1;
        code_q <= key.key_code;
        brk_q  <= key.key_break;
      end else if (tx_done) begin
        busy <= 1'b0;
      end
    end
  end

  // DONE also accepts, so an event offered right after busy drops starts without a bubble.
  always_comb begin
    state_n   = state;
    ser_start = kick;
    tx_done   = 1'b0;
    case (state)
      IDLE, DONE: state_n = accept ? first_state : IDLE;
      SEND_EXT: if (frame_done) begin
        state_n   = brk_q ? SEND_PFX : SEND_CODE;
        ser_start = 1'b1;
      end
      SEND_PFX: if (frame_done) begin
        state_n   = SEND_CODE;
        ser_start = 1'b1;
      end
      SEND_CODE: if (frame_done) begin
        state_n = DONE;
        tx_done = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Chained frames load on the final gap cycle, so pick the byte for the state being entered.
    ser_sel = frame_done ? state_n : state;
    case (ser_sel)
      SEND_EXT: ser_byte = PS2_EXT_PFX;
      SEND_PFX: ser_byte = PS2_BREAK_PFX;
      default:  ser_byte = code_q;
    endcase
  end

  ps2_frame_ser #(
    .CLK_HALF   (CLK_HALF),
    .GAP_HALVES (GAP_HALVES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .tx_byte    (ser_byte),
    .start      (ser_start),
    .frame_done (frame_done),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx at CLK_HALF=4, GAP_HALVES=2 (96 cycles per frame); a falling-edge receiver feeds a byte scoreboard.
module tb_ps2_kbd_tx;
  localparam int CH = 4;
  localparam int GH = 2;
  localparam int FRAME = 22 * CH + GH * CH;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk, ps2_data, busy, tx_done;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   neg_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] rx_q[$];
  logic [10:0] rx_sh;
  int          nbits = 0;

  ps2_kbd_tx_if kif ();

  ps2_kbd_tx #(.CLK_HALF(CH), .GAP_HALVES(GH)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (kif),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  // Host-side receiver: sample data on every falling ps2_clk, 11 bits per frame.
  always @(negedge ps2_clk or negedge rst) begin
    if (!rst) begin
      nbits = 0;
    end else begin
      neg_cnt++;
      rx_sh[nbits] = ps2_data;
      nbits++;
      if (nbits == 11) begin
        rx_q.push_back(rx_sh);
        nbits = 0;
      end
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      if (kif.key_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        step(1);
      end
    end
  endtask

  task automatic wait_done(output int dn, inout int rdy_hi);
    dn = -1;
    for (int i = 0; i < 400 && dn < 0; i++) begin
      if (kif.key_ready) rdy_hi++;
      if (tx_done) dn = cyc;
      else step(1);
    end
  endtask

  task automatic run_event(input logic [7:0] code, input logic brk, input logic ext,
                           output int acc, output int dn, output int rdy_hi);
    kif.key_code  = code;
    kif.key_break = brk;
`ifdef PS2_EXT_KEY_EN
    kif.key_ext   = ext;
    if (ext) exp_q.push_back(8'hE0);
`endif
    if (brk) exp_q.push_back(8'hF0);
    exp_q.push_back(code);
    kif.key_valid = 1'b1;
    wait_accept(acc);
    kif.key_valid = 1'b0;
    rdy_hi = 0;
    wait_done(dn, rdy_hi);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_code  = 8'h00;
    kif.key_break = 1'b0;
`ifdef PS2_EXT_KEY_EN
    kif.key_ext   = 1'b0;
`endif
    #23;
    checks++; if (ps2_clk !== 1'b1)     begin errors++; $display("FAIL reset_clk got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1)    begin errors++; $display("FAIL reset_data got %b want 1", ps2_data); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    checks++; if (kif.key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", kif.key_ready); end
    #4 rst = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid_frame();
    int acc, neg0;
    kif.key_code  = 8'h00;
    kif.key_break = 1'b0;
    kif.key_valid = 1'b1;
    wait_accept(acc);
    kif.key_valid = 1'b0;
    step(30);
    #2 rst = 1'b0;
    #1;
    neg0 = neg_cnt;
    checks++; if (ps2_clk !== 1'b1)  begin errors++; $display("FAIL midrst_clk got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL midrst_data got %b want 1", ps2_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    #3 rst = 1'b1;
    step(120);
    checks++; if (kif.key_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", kif.key_ready); end
    checks++; if (neg_cnt != neg0) begin errors++; $display("FAIL midrst_edges got %0d want %0d", neg_cnt, neg0); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_frames got %0d want 0", rx_q.size()); end
    rx_q.delete();
  endtask

  task automatic test_make();
    int acc, dn, rh;
    logic [7:0] eb;
    logic [10:0] rf;
    run_event(8'h1C, 1'b0, 1'b0, acc, dn, rh);
    checks++; if (dn - acc != FRAME) begin errors++; $display("FAIL make_latency got %0d want %0d", dn - acc, FRAME); end
    checks++; if (rh != 0) begin errors++; $display("FAIL make_ready_busy got %0d want 0", rh); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL make_busy_drop got %b want 0", busy); end
    checks++; if (rx_q.size() > 0 && rx_q[0] !== 11'h438) begin errors++; $display("FAIL make_bits got %h want 438", rx_q[0]); end
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL make_frame got none want %h", eb); end
      else begin
        rf = rx_q.pop_front();
        if (rf !== frame_of(eb)) begin errors++; $display("FAIL make_frame got %h want %h", rf, frame_of(eb)); end
      end
    end
  endtask

  task automatic test_break();
    int acc, dn, rh, d0;
    logic [7:0] eb;
    logic [10:0] rf;
    d0 = done_cnt;
    run_event(8'h1C, 1'b1, 1'b0, acc, dn, rh);
    checks++; if (dn - acc != 2 * FRAME) begin errors++; $display("FAIL break_latency got %0d want %0d", dn - acc, 2 * FRAME); end
    step(4);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL break_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (rx_q.size() > 0 && rx_q[0] !== 11'h7E0) begin errors++; $display("FAIL break_f0_bits got %h want 7e0", rx_q[0]); end
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL break_frame got none want %h", eb); end
      else begin
        rf = rx_q.pop_front();
        if (rf !== frame_of(eb)) begin errors++; $display("FAIL break_frame got %h want %h", rf, frame_of(eb)); end
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] codes [3] = '{8'h00, 8'hFF, 8'h01};
    logic       pars  [3] = '{1'b1, 1'b1, 1'b0};
    int acc, dn, rh;
    logic [7:0] eb;
    logic [10:0] rf;
    for (int k = 0; k < 3; k++) begin
      run_event(codes[k], 1'b0, 1'b0, acc, dn, rh);
      step(2);
      eb = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL parity_frame got none want %h", eb); end
      else begin
        rf = rx_q.pop_front();
        if (rf[9] !== pars[k]) begin errors++; $display("FAIL parity_bit code %h got %b want %b", eb, rf[9], pars[k]); end
        checks++; if (rf[10] !== 1'b1) begin errors++; $display("FAIL parity_stop code %h got %b want 1", eb, rf[10]); end
        checks++; if (rf[8:1] !== eb) begin errors++; $display("FAIL parity_data got %h want %h", rf[8:1], eb); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d1, d2, rh;
    logic [7:0] eb;
    logic [10:0] rf;
    rh = 0;
    kif.key_code  = 8'h1C;
    kif.key_break = 1'b0;
    kif.key_valid = 1'b1;
    exp_q.push_back(8'h1C);
    wait_accept(acc1);
    kif.key_break = 1'b1;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    wait_done(d1, rh);
    step(1);
    wait_accept(acc2);
    kif.key_valid = 1'b0;
    wait_done(d2, rh);
    checks++; if (acc2 - d1 != 2) begin errors++; $display("FAIL b2b_accept got %0d want 2", acc2 - d1); end
    checks++; if (d2 - acc2 != 2 * FRAME) begin errors++; $display("FAIL b2b_latency got %0d want %0d", d2 - acc2, 2 * FRAME); end
    checks++; if (rh != 0) begin errors++; $display("FAIL b2b_ready_busy got %0d want 0", rh); end
    step(2);
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL b2b_frame got none want %h", eb); end
      else begin
        rf = rx_q.pop_front();
        if (rf !== frame_of(eb)) begin errors++; $display("FAIL b2b_frame got %h want %h", rf, frame_of(eb)); end
      end
    end
  endtask

`ifdef PS2_EXT_KEY_EN
  task automatic test_ext();
    int acc, dn, rh;
    logic [7:0] eb;
    logic [10:0] rf;
    run_event(8'h75, 1'b1, 1'b1, acc, dn, rh);
    checks++; if (dn - acc != 3 * FRAME) begin errors++; $display("FAIL ext_latency got %0d want %0d", dn - acc, 3 * FRAME); end
    step(2);
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL ext_frame got none want %h", eb); end
      else begin
        rf = rx_q.pop_front();
        if (rf !== frame_of(eb)) begin errors++; $display("FAIL ext_frame got %h want %h", rf, frame_of(eb)); end
      end
    end
    kif.key_ext = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_make();
    test_break();
    test_parity();
    test_back_to_back();
`ifdef PS2_EXT_KEY_EN
    test_ext();
`endif
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL leftover_frames got %0d want 0", rx_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
